ip_fetch_unit: RTL and testbench

Instruction-fetch initiator for the IP side of DekatronPC. It holds the BCD instruction pointer (IP) and issues Request/Ready transactions to the IP instruction memory, which is the responder. It captures the returned instruction into a one-entry buffer for the core and steps the IP forward or backward; backward stepping serves loop-bracket scans. It also supports absolute IP loads for jumps and for the bootloader vector.

---
 rtl/ip_fetch_unit.sv | 159 +++++++++++++++
 tb/tb_ip_fetch_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_fetch_unit.sv
// IP-side instruction fetch initiator: holds the BCD instruction pointer, runs
// Request/Ready fetches against instruction memory and buffers one instruction.
//
// state  | meaning
// -------+--------------------------------------------------------------
// REQ    | one-cycle MemRequest pulse for the instruction at Ip
// SETTLE | request dropped; MemReady ignored (may be stale from last fetch)
// WAIT   | wait for MemReady, capture MemInsn; timeout leads to ERR
// IDLE   | instruction buffered; accept Load or Step
// ERR    | memory timed out; frozen until reset
module ip_fetch_unit #(
  parameter int IP_DEKATRON_NUM = 6,
  parameter int DEKATRON_WIDTH  = 4,
  parameter int INSN_WIDTH      = 4,
  parameter logic [IP_DEKATRON_NUM*DEKATRON_WIDTH-1:0] RESET_IP = 24'h999900,
  parameter int TIMEOUT         = 16
) (
  input  logic                                      Clk,
  input  logic                                      Rst_n,
  input  logic                                      Step,
  input  logic                                      Dir,
  input  logic                                      Load,
  input  logic [IP_DEKATRON_NUM*DEKATRON_WIDTH-1:0] LoadAddr,
  output logic [IP_DEKATRON_NUM*DEKATRON_WIDTH-1:0] Ip,
  output logic [INSN_WIDTH-1:0]                     Insn,
  output logic                                      InsnValid,
  output logic                                      Busy,
  output logic                                      Error,
  output logic                                      MemRequest,
  input  logic                                      MemReady,
  output logic [IP_DEKATRON_NUM*DEKATRON_WIDTH-1:0] MemAddress,
  input  logic [INSN_WIDTH-1:0]                     MemInsn
);

  localparam int IP_W  = IP_DEKATRON_NUM * DEKATRON_WIDTH;
  localparam int DW    = DEKATRON_WIDTH;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LOAD  = CNT_W'(TIMEOUT - 1);
  localparam logic [DW-1:0]    DIGIT_MAX = DW'(9);
  localparam logic [DW-1:0]    DIGIT_ONE = DW'(1);

  typedef enum logic [2:0] {
    S_REQ    = 3'd0,
    S_SETTLE = 3'd1,
    S_WAIT   = 3'd2,
    S_IDLE   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [IP_W-1:0]       ip_q, ip_inc, ip_dec;
  logic [INSN_WIDTH-1:0] insn_q;
  logic                  valid_q, error_q;
  logic [CNT_W-1:0]      tmo_q;
  logic                  inc_carry, dec_borrow;
  logic                  accept_load, accept_step, capture, timeout;

  always_ff @(posedge Clk) begin
    if (!Rst_n) state_q <= S_REQ;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_REQ:    state_d = S_SETTLE;
      S_SETTLE: state_d = S_WAIT;
      S_WAIT: begin
        if (MemReady)          state_d = S_IDLE;
        else if (tmo_q == '0)  state_d = S_ERR;
      end
      S_IDLE:   if (Load || Step) state_d = S_REQ;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_REQ;
    endcase
  end

  // Reset holds state at REQ, so the request/busy outputs are masked by Rst_n
  // to read idle while reset is asserted.
  always_comb begin
    MemRequest  = Rst_n && (state_q == S_REQ);
    Busy        = Rst_n && ((state_q == S_REQ) || (state_q == S_SETTLE) ||
                            (state_q == S_WAIT));
    capture     = (state_q == S_WAIT) && MemReady;
    timeout     = (state_q == S_WAIT) && !MemReady && (tmo_q == '0);
    accept_load = (state_q == S_IDLE) && Load;
    accept_step = (state_q == S_IDLE) && Step && !Load;
  end

  always_comb begin
    ip_inc    = ip_q;
    inc_carry = 1'b1;
    for (int i = 0; i < IP_DEKATRON_NUM; i++) begin
      if (inc_carry) begin
        if (ip_q[i*DW +: DW] >= DIGIT_MAX) begin
          ip_inc[i*DW +: DW] = '0;
        end else begin
          ip_inc[i*DW +: DW] = ip_q[i*DW +: DW] + DIGIT_ONE;
          inc_carry = 1'b0;
        end
      end
    end
  end

  // Non-BCD digits saturate to 9 without borrowing.
  always_comb begin
    ip_dec     = ip_q;
    dec_borrow = 1'b1;
    for (int i = 0; i < IP_DEKATRON_NUM; i++) begin
      if (dec_borrow) begin
        if (ip_q[i*DW +: DW] == '0) begin
          ip_dec[i*DW +: DW] = DIGIT_MAX;
        end else if (ip_q[i*DW +: DW] > DIGIT_MAX) begin
          ip_dec[i*DW +: DW] = DIGIT_MAX;
          dec_borrow = 1'b0;
        end else begin
          ip_dec[i*DW +: DW] = ip_q[i*DW +: DW] - DIGIT_ONE;
          dec_borrow = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      ip_q    <= RESET_IP;
      insn_q  <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      tmo_q   <= TMO_LOAD;
    end else begin
      if (accept_load) begin
        ip_q    <= LoadAddr;
        valid_q <= 1'b0;
      end else if (accept_step) begin
        ip_q    <= Dir ? ip_dec : ip_inc;
        valid_q <= 1'b0;
      end
      if (capture) begin
        insn_q  <= MemInsn;
        valid_q <= 1'b1;
      end
      // Down-counter: TIMEOUT wait cycles end at terminal count zero.
      if (state_q == S_SETTLE)
        tmo_q <= TMO_LOAD;
      else if ((state_q == S_WAIT) && !MemReady && (tmo_q != '0))
        tmo_q <= tmo_q - CNT_W'(1);
      if (timeout) error_q <= 1'b1;
    end
  end

  assign Ip         = ip_q;
  assign MemAddress = ip_q;
  assign Insn       = insn_q;
  assign InsnValid  = valid_q;
  assign Error      = error_q;

endmodule

// File: tb/tb_ip_fetch_unit.sv
// Directed bench for ip_fetch_unit: a vector table of Load/Step fetches plus
// hand sequences for reset release, stale Ready, ignored Step, timeout and reset in WAIT.
module tb_ip_fetch_unit;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Step = 1'b0;
  logic        Dir = 1'b0;
  logic        Load = 1'b0;
  logic [23:0] LoadAddr = '0;
  logic [23:0] Ip;
  logic [3:0]  Insn;
  logic        InsnValid;
  logic        Busy;
  logic        Error;
  logic        MemRequest;
  logic        MemReady;
  logic [23:0] MemAddress;
  logic [3:0]  MemInsn;

  int passed = 0;
  int total  = 0;

  always #5 Clk = ~Clk;

  ip_fetch_unit dut (
    .Clk(Clk), .Rst_n(Rst_n), .Step(Step), .Dir(Dir), .Load(Load),
    .LoadAddr(LoadAddr), .Ip(Ip), .Insn(Insn), .InsnValid(InsnValid),
    .Busy(Busy), .Error(Error), .MemRequest(MemRequest), .MemReady(MemReady),
    .MemAddress(MemAddress), .MemInsn(MemInsn)
  );

  // Responder: latches address on request, raises Ready after 'delay' extra
  // cycles. stale_mode shows a bogus Ready (data F) in the cycle after request.
  int         delay = 0;
  bit         stuck = 1'b0;
  bit         stale_mode = 1'b0;
  logic       rdy_q = 1'b0;
  logic       stale_q = 1'b0;
  int         cnt = 0;
  logic [3:0] data_q = '0;

  function automatic logic [3:0] mem_f(input logic [23:0] a);
    if (a == 24'h999900) return 4'hA;
    return a[3:0] + a[7:4] + a[11:8] + 4'd3;
  endfunction

  always @(posedge Clk) begin
    stale_q <= 1'b0;
    if (MemRequest) begin
      rdy_q   <= 1'b0;
      cnt     <= delay;
      data_q  <= mem_f(MemAddress);
      stale_q <= stale_mode;
    end else if (!stuck && !rdy_q) begin
      if (cnt == 0) rdy_q <= 1'b1;
      else          cnt <= cnt - 1;
    end
  end

  assign MemReady = (rdy_q | stale_q) & ~MemRequest;
  assign MemInsn  = rdy_q ? data_q : 4'hF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      passed++;
  endtask

  // Called at a negedge with the DUT in IDLE; expects a zero-wait fetch.
  task automatic run_fetch(input int idx, input logic ld, input logic st, input logic dr,
                           input logic [23:0] ad, input logic [23:0] exp_ip,
                           input logic [3:0] exp_insn);
    int lat;
    int reqs;
    Load = ld; Step = st; Dir = dr; LoadAddr = ad;
    @(posedge Clk); #1;
    Load = 1'b0; Step = 1'b0;
    @(negedge Clk);
    chk($sformatf("v%0d req", idx), MemRequest, 1);
    chk($sformatf("v%0d addr", idx), MemAddress, exp_ip);
    lat = 1; reqs = 1;
    while (!InsnValid && lat < 40) begin
      @(negedge Clk);
      lat++;
      if (MemRequest) reqs++;
    end
    chk($sformatf("v%0d latency", idx), lat, 4);
    chk($sformatf("v%0d reqs", idx), reqs, 1);
    chk($sformatf("v%0d ip", idx), Ip, exp_ip);
    chk($sformatf("v%0d insn", idx), Insn, exp_insn);
  endtask

  typedef struct {
    logic        load;
    logic        step;
    logic        dir;
    logic [23:0] addr;
    logic [23:0] exp_ip;
    logic [3:0]  exp_insn;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int lat;
    int reqs;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 24'h000099, 24'h000099, 4'h5};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 24'h000000, 24'h000100, 4'h4};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 24'h000000, 24'h000099, 4'h5};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 24'h999999, 24'h999999, 4'hE};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 24'h000000, 24'h000000, 4'h3};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 24'h000000, 24'h999999, 4'hE};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 24'h001234, 24'h001234, 4'hC};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 24'h000000, 24'h001233, 4'hB};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 24'h0000A9, 24'h0000A9, 4'h6};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 24'h000000, 24'h000100, 4'h4};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 24'h0000B0, 24'h0000B0, 4'hE};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 24'h000000, 24'h000099, 4'h5};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 24'h199999, 24'h199999, 4'hE};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 24'h000000, 24'h200000, 4'h3};

    // Reset values
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst ip", Ip, 24'h999900);
    chk("rst insn", Insn, 0);
    chk("rst valid", InsnValid, 0);
    chk("rst error", Error, 0);
    chk("rst req", MemRequest, 0);
    chk("rst busy", Busy, 0);

    // Release: cycle 1 is the cycle after the last reset edge
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    @(negedge Clk);
    chk("boot req c1", MemRequest, 1);
    chk("boot addr c1", MemAddress, 24'h999900);
    chk("boot busy c1", Busy, 1);
    @(negedge Clk);
    chk("boot req c2", MemRequest, 0);
    @(negedge Clk);
    chk("boot valid c3", InsnValid, 0);
    @(negedge Clk);
    chk("boot valid c4", InsnValid, 1);
    chk("boot insn c4", Insn, 4'hA);
    @(negedge Clk);
    chk("boot busy c5", Busy, 0);

    for (int i = 0; i < 14; i++)
      run_fetch(i, vecs[i].load, vecs[i].step, vecs[i].dir, vecs[i].addr,
                vecs[i].exp_ip, vecs[i].exp_insn);

    // Stale Ready during SETTLE must not be captured
    stale_mode = 1'b1;
    run_fetch(100, 1'b1, 1'b0, 1'b0, 24'h000000, 24'h000000, 4'h3);
    stale_mode = 1'b0;

    // Step held during REQ/SETTLE/WAIT is ignored
    delay = 3;
    Load = 1'b1; LoadAddr = 24'h000500;
    @(posedge Clk); #1;
    Load = 1'b0; Step = 1'b1; Dir = 1'b0;
    lat = 0; reqs = 0;
    while (!InsnValid && lat < 40) begin
      @(negedge Clk);
      lat++;
      if (MemRequest) reqs++;
      if (lat == 4) Step = 1'b0;
    end
    chk("ign latency", lat, 7);
    chk("ign reqs", reqs, 1);
    chk("ign ip", Ip, 24'h000500);
    chk("ign insn", Insn, 4'h8);

    // Timeout: 16 WAIT cycles without Ready
    delay = 0; stuck = 1'b1;
    Step = 1'b1; Dir = 1'b0;
    @(posedge Clk); #1;
    Step = 1'b0;
    repeat (18) @(negedge Clk);
    chk("tmo error c18", Error, 0);
    chk("tmo busy c18", Busy, 1);
    @(negedge Clk);
    chk("tmo error c19", Error, 1);
    chk("tmo busy c19", Busy, 0);
    Step = 1'b1; Load = 1'b1; LoadAddr = 24'h123456;
    reqs = 0;
    repeat (4) begin
      @(negedge Clk);
      if (MemRequest) reqs++;
    end
    Step = 1'b0; Load = 1'b0;
    chk("err reqs", reqs, 0);
    chk("err ip", Ip, 24'h000501);
    chk("err sticky", Error, 1);

    // Reset clears ERR
    stuck = 1'b0;
    Rst_n = 1'b0;
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    @(negedge Clk);
    chk("clr error", Error, 0);
    chk("clr ip", Ip, 24'h999900);
    lat = 1;
    while (!InsnValid && lat < 40) begin
      @(negedge Clk);
      lat++;
    end
    chk("clr latency", lat, 4);
    chk("clr insn", Insn, 4'hA);

    // Reset asserted while in WAIT with the responder mid-transaction
    delay = 8;
    Step = 1'b1; Dir = 1'b1;
    @(posedge Clk); #1;
    Step = 1'b0;
    repeat (4) @(negedge Clk);
    chk("wrst ip before", Ip, 24'h999899);
    chk("wrst busy before", Busy, 1);
    Rst_n = 1'b0;
    delay = 0;
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    @(negedge Clk);
    chk("wrst ip", Ip, 24'h999900);
    chk("wrst valid", InsnValid, 0);
    chk("wrst error", Error, 0);
    chk("wrst req", MemRequest, 1);
    lat = 1;
    while (!InsnValid && lat < 40) begin
      @(negedge Clk);
      lat++;
    end
    chk("wrst latency", lat, 4);
    chk("wrst insn", Insn, 4'hA);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
